// File: rtl/decode_stage_pkg.sv
// Field enumerations and shared types for the decode stage.
//   opcode : major opcode values (instruction bits 6:0)
//   funct3 : minor function values (bits 14:12)
//   funct7 : funct7 values (bits 31:25) and the alternate-op bit position
//   riscv  : widths, ir_t union views, ALU function, next-PC select,
//            control flags and the decoded-instruction record.

package opcode;
    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        OP_IMM = 7'b0010011,
        AUIPC  = 7'b0010111,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        LUI    = 7'b0110111,
        BRANCH = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111
    } opcode_t;
endpackage

package funct3;
    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SLL  = 3'd1,
        SLT  = 3'd2,
        SLTU = 3'd3,
        XOR  = 3'd4,
        SRL  = 3'd5,
        OR   = 3'd6,
        AND  = 3'd7
    } funct3_t;
endpackage

package funct7;
    typedef enum logic [6:0] {
        BASE = 7'b0000000,
        ALT  = 7'b0100000
    } funct7_t;
    // SUB/SRA select bit inside funct7
    localparam int ALT_BIT = 5;
endpackage

package riscv;
    typedef logic [8:0]  pc_t;
    typedef logic [4:0]  addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [6:0] funct7;
        addr_t      rs2;
        addr_t      rs1;
        logic [2:0] funct3;
        addr_t      rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef struct packed {
        logic        imm_11;
        logic [10:0] imm_10_0;
        addr_t       rs1;
        logic [2:0]  funct3;
        addr_t       rd;
        logic [6:0]  opcode;
    } i_type_t;

    typedef struct packed {
        logic [6:0] imm_11_5;
        addr_t      rs2;
        addr_t      rs1;
        logic [2:0] funct3;
        logic [4:0] imm_4_0;
        logic [6:0] opcode;
    } s_type_t;

    typedef struct packed {
        logic       imm_12;
        logic [5:0] imm_10_5;
        addr_t      rs2;
        addr_t      rs1;
        logic [2:0] funct3;
        logic [3:0] imm_4_1;
        logic       imm_11;
        logic [6:0] opcode;
    } sb_type_t;

    typedef struct packed {
        logic [19:0] imm_31_12;
        addr_t       rd;
        logic [6:0]  opcode;
    } u_type_t;

    typedef struct packed {
        logic       imm_20;
        logic [9:0] imm_10_1;
        logic       imm_11;
        logic [7:0] imm_19_12;
        addr_t      rd;
        logic [6:0] opcode;
    } uj_type_t;

    typedef union packed {
        r_type_t  r;
        i_type_t  i;
        s_type_t  s;
        sb_type_t sb;
        u_type_t  u;
        uj_type_t uj;
    } ir_t;

    // ADDI x0,x0,0
    localparam ir_t NOP = ir_t'(32'h0000_0013);

    // {alt, funct3}
    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SLL  = 4'b0001,
        SLT  = 4'b0010,
        SLTU = 4'b0011,
        XOR  = 4'b0100,
        SRL  = 4'b0101,
        OR   = 4'b0110,
        AND  = 4'b0111,
        SUB  = 4'b1000,
        SRA  = 4'b1101
    } funct_t;

    typedef enum logic [1:0] {
        NEXT = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2
    } pc_sel_t;

    typedef struct packed {
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        pc_t     pc;
        addr_t   rs1;
        addr_t   rs2;
        addr_t   rd;
        word_t   imm;
        funct_t  funct;
        pc_sel_t pc_sel;
        ctrl_t   ctrl;
    } dec_t;

    localparam dec_t DEC_RST = '{
        pc: '0, rs1: '0, rs2: '0, rd: '0, imm: '0,
        funct: ADD, pc_sel: NEXT, ctrl: '0
    };
endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
//   master : fetch/execute side (drives in_*, flush, out_ready)
//   slave  : decode stage (drives in_ready, out_*)

interface decode_stage_if;
    import riscv::*;

    logic    in_valid;
    logic    in_ready;
    ir_t     in_ir;
    pc_t     in_pc;
    logic    flush;
    logic    out_valid;
    logic    out_ready;
    pc_t     out_pc;
    addr_t   out_rs1;
    addr_t   out_rs2;
    addr_t   out_rd;
    word_t   out_imm;
    funct_t  out_funct;
    pc_sel_t out_pc_sel;
    logic    out_reg_wr;
    logic    out_mem_rd;
    logic    out_mem_wr;
    logic    out_branch;
    logic    out_illegal;

    modport master (
        output in_valid, in_ir, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_funct, out_pc_sel, out_reg_wr, out_mem_rd,
               out_mem_wr, out_branch, out_illegal
    );

    modport slave (
        input  in_valid, in_ir, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_funct, out_pc_sel, out_reg_wr, out_mem_rd,
               out_mem_wr, out_branch, out_illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the ir_t view by opcode and sign-extends to 32 bits.
//   ir  in  : instruction word
//   imm out : immediate (0 for OP and unknown opcodes)

module imm_gen
    import riscv::*;
(
    input  ir_t   ir,
    output word_t imm
);
    always_comb begin
        imm = '0;
        case (ir.r.opcode)
            opcode::OP_IMM: begin
                // shift-immediates carry shamt in bits 24:20; funct7 is not part of the value
                if (ir.i.funct3 == funct3::SLL || ir.i.funct3 == funct3::SRL)
                    imm = {27'b0, ir.r.rs2};
                else
                    imm = {{20{ir.i.imm_11}}, ir.i.imm_11, ir.i.imm_10_0};
            end
            opcode::LOAD, opcode::JALR:
                imm = {{20{ir.i.imm_11}}, ir.i.imm_11, ir.i.imm_10_0};
            opcode::STORE:
                imm = {{20{ir.s.imm_11_5[6]}}, ir.s.imm_11_5, ir.s.imm_4_0};
            opcode::BRANCH:
                imm = {{19{ir.sb.imm_12}}, ir.sb.imm_12, ir.sb.imm_11,
                       ir.sb.imm_10_5, ir.sb.imm_4_1, 1'b0};
            opcode::LUI, opcode::AUIPC:
                imm = {ir.u.imm_31_12, 12'b0};
            opcode::JAL:
                imm = {{11{ir.uj.imm_20}}, ir.uj.imm_20, ir.uj.imm_19_12,
                       ir.uj.imm_11, ir.uj.imm_10_1, 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: splits an instruction word into register addresses,
// immediate, ALU function and control flags, held in a single output register.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready/in_ir/in_pc from fetch, flush,
//                 out_valid/out_ready and decoded out_* fields to execute

module decode_stage
    import riscv::*;
(
    input logic         clk,
    input logic         resetn,
    decode_stage_if.slave bus
);
    dec_t  dec_d;
    dec_t  dec_q;
    logic  out_vld_q;
    word_t imm;
    logic  in_xfer;
    logic  out_xfer;
    logic  legal;
    logic  uses_rs1;
    logic  uses_rs2;
    logic  wr;

    assign bus.in_ready = !out_vld_q || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = out_vld_q && bus.out_ready;

    imm_gen u_imm_gen (
        .ir  (bus.in_ir),
        .imm (imm)
    );

    always_comb begin
        dec_d     = DEC_RST;
        legal     = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        wr        = 1'b0;
        dec_d.pc  = bus.in_pc;
        dec_d.rs1 = bus.in_ir.r.rs1;
        dec_d.rs2 = bus.in_ir.r.rs2;
        dec_d.rd  = bus.in_ir.r.rd;
        dec_d.imm = imm;
        case (bus.in_ir.r.opcode)
            opcode::OP: begin
                uses_rs2    = 1'b1;
                wr          = 1'b1;
                dec_d.funct = funct_t'({bus.in_ir.r.funct7[funct7::ALT_BIT],
                                        bus.in_ir.r.funct3});
            end
            opcode::OP_IMM: begin
                wr          = 1'b1;
                // only SRAI uses the alternate bit; for other funct3 it is immediate data
                dec_d.funct = funct_t'({bus.in_ir.r.funct7[funct7::ALT_BIT] &&
                                        (bus.in_ir.r.funct3 == funct3::SRL),
                                        bus.in_ir.r.funct3});
            end
            opcode::LOAD: begin
                wr                 = 1'b1;
                dec_d.ctrl.mem_rd  = 1'b1;
            end
            opcode::STORE: begin
                uses_rs2           = 1'b1;
                dec_d.ctrl.mem_wr  = 1'b1;
            end
            opcode::BRANCH: begin
                uses_rs2           = 1'b1;
                dec_d.ctrl.branch  = 1'b1;
            end
            opcode::LUI, opcode::AUIPC: begin
                uses_rs1 = 1'b0;
                wr       = 1'b1;
            end
            opcode::JAL: begin
                uses_rs1     = 1'b0;
                wr           = 1'b1;
                dec_d.pc_sel = JAL;
            end
            opcode::JALR: begin
                wr           = 1'b1;
                dec_d.pc_sel = JALR;
            end
            default: legal = 1'b0;
        endcase
        if (!uses_rs1) dec_d.rs1 = '0;
        if (!uses_rs2) dec_d.rs2 = '0;
        dec_d.ctrl.reg_wr = wr && (dec_d.rd != '0);
        // unknown opcode is presented as a NOP tagged illegal
        if (!legal) begin
            dec_d              = DEC_RST;
            dec_d.pc           = bus.in_pc;
            dec_d.ctrl.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_vld_q <= 1'b0;
            dec_q     <= DEC_RST;
        end else if (bus.flush) begin
            // any input accepted this cycle is dropped
            out_vld_q <= 1'b0;
            dec_q     <= DEC_RST;
        end else if (in_xfer) begin
            out_vld_q <= 1'b1;
            dec_q     <= dec_d;
        end else if (out_xfer) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_vld_q;
    assign bus.out_pc      = dec_q.pc;
    assign bus.out_rs1     = dec_q.rs1;
    assign bus.out_rs2     = dec_q.rs2;
    assign bus.out_rd      = dec_q.rd;
    assign bus.out_imm     = dec_q.imm;
    assign bus.out_funct   = dec_q.funct;
    assign bus.out_pc_sel  = dec_q.pc_sel;
    assign bus.out_reg_wr  = dec_q.ctrl.reg_wr;
    assign bus.out_mem_rd  = dec_q.ctrl.mem_rd;
    assign bus.out_mem_wr  = dec_q.ctrl.mem_wr;
    assign bus.out_branch  = dec_q.ctrl.branch;
    assign bus.out_illegal = dec_q.ctrl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural decode model.

module tb_decode_stage;
    import riscv::*;

    logic clk;
    logic resetn;
    int   n_chk  = 0;
    int   n_fail = 0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        dec_t        d;
    } vec_t;

    localparam dec_t RST_EXP = '{
        pc: 9'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
        funct: ADD, pc_sel: NEXT, ctrl: 5'b00000
    };

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input dec_t e);
        chk({tag, ".valid"},   32'(bus.out_valid), 32'(ev));
        chk({tag, ".pc"},      32'(bus.out_pc), 32'(e.pc));
        chk({tag, ".rs1"},     32'(bus.out_rs1), 32'(e.rs1));
        chk({tag, ".rs2"},     32'(bus.out_rs2), 32'(e.rs2));
        chk({tag, ".rd"},      32'(bus.out_rd), 32'(e.rd));
        chk({tag, ".imm"},     bus.out_imm, e.imm);
        chk({tag, ".funct"},   32'(bus.out_funct), 32'(e.funct));
        chk({tag, ".pc_sel"},  32'(bus.out_pc_sel), 32'(e.pc_sel));
        chk({tag, ".flags"},
            32'({bus.out_reg_wr, bus.out_mem_rd, bus.out_mem_wr, bus.out_branch, bus.out_illegal}),
            32'(e.ctrl));
    endtask

    function automatic vec_t mk(logic [31:0] ir, pc_t pc, addr_t rs1, addr_t rs2, addr_t rd,
                                word_t imm, funct_t f, pc_sel_t s, logic [4:0] fl);
        vec_t v;
        v.ir = ir;
        v.d  = '{pc: pc, rs1: rs1, rs2: rs2, rd: rd, imm: imm, funct: f, pc_sel: s, ctrl: fl};
        return v;
    endfunction

    // Reference decode straight from the instruction rules on the raw word.
    function automatic dec_t ref_decode(logic [31:0] w, pc_t pc);
        dec_t       r;
        logic [6:0] op;
        logic [2:0] f3;
        int         imm;
        op   = w[6:0];
        f3   = w[14:12];
        r    = RST_EXP;
        r.pc = pc;
        if (!(op inside {opcode::OP, opcode::OP_IMM, opcode::LOAD, opcode::STORE, opcode::BRANCH,
                         opcode::LUI, opcode::AUIPC, opcode::JAL, opcode::JALR})) begin
            r.ctrl.illegal = 1'b1;
            return r;
        end
        imm = 0;
        case (op)
            opcode::OP_IMM: imm = (f3 == 3'd1 || f3 == 3'd5) ? int'(w[24:20]) : int'($signed(w[31:20]));
            opcode::LOAD, opcode::JALR: imm = int'($signed(w[31:20]));
            opcode::STORE:  imm = int'($signed({w[31:25], w[11:7]}));
            opcode::BRANCH: imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            opcode::LUI, opcode::AUIPC: imm = int'({w[31:12], 12'b0});
            opcode::JAL:    imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: imm = 0;
        endcase
        r.imm = imm;
        r.rd  = w[11:7];
        r.rs1 = (op inside {opcode::LUI, opcode::AUIPC, opcode::JAL}) ? 5'd0 : w[19:15];
        r.rs2 = (op inside {opcode::OP, opcode::STORE, opcode::BRANCH}) ? w[24:20] : 5'd0;
        if (op == opcode::OP) r.funct = funct_t'({w[30], f3});
        else if (op == opcode::OP_IMM) r.funct = funct_t'({w[30] && f3 == 3'd5, f3});
        r.pc_sel = (op == opcode::JAL) ? JAL : (op == opcode::JALR) ? JALR : NEXT;
        r.ctrl.reg_wr = (op inside {opcode::OP, opcode::OP_IMM, opcode::LOAD, opcode::LUI,
                                    opcode::AUIPC, opcode::JAL, opcode::JALR}) && w[11:7] != 5'd0;
        r.ctrl.mem_rd = (op == opcode::LOAD);
        r.ctrl.mem_wr = (op == opcode::STORE);
        r.ctrl.branch = (op == opcode::BRANCH);
        return r;
    endfunction

    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h67, 7'h7F, 7'h0B};

    initial begin
        logic        m_valid;
        dec_t        m_dec;
        logic [31:0] w;

        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ir     = ir_t'(32'h0000_0013);
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        //                 ir            pc      rs1 rs2 rd  imm            funct pc_sel flags
        vecs[0]  = mk(32'hFFF00293, 9'd4,   0,  0,  5,  32'hFFFFFFFF, ADD,  NEXT, 5'b10000); // ADDI x5,x0,-1
        vecs[1]  = mk(32'h402081B3, 9'd8,   1,  2,  3,  32'h0,        SUB,  NEXT, 5'b10000); // SUB x3,x1,x2
        vecs[2]  = mk(32'h40325213, 9'd12,  4,  0,  4,  32'h3,        SRA,  NEXT, 5'b10000); // SRAI x4,x4,3
        vecs[3]  = mk(32'hFF9FF0EF, 9'd16,  0,  0,  1,  32'hFFFFFFF8, ADD,  JAL,  5'b10000); // JAL x1,-8
        vecs[4]  = mk(32'h00208863, 9'd20,  1,  2,  16, 32'h10,       ADD,  NEXT, 5'b00010); // BEQ x1,x2,+16
        vecs[5]  = mk(32'h1234567F, 9'd24,  0,  0,  0,  32'h0,        ADD,  NEXT, 5'b00001); // illegal
        vecs[6]  = mk(32'h0080A103, 9'd28,  1,  0,  2,  32'h8,        ADD,  NEXT, 5'b11000); // LW x2,8(x1)
        vecs[7]  = mk(32'hFE20AE23, 9'd32,  1,  2,  28, 32'hFFFFFFFC, ADD,  NEXT, 5'b00100); // SW x2,-4(x1)
        vecs[8]  = mk(32'h123453B7, 9'd36,  0,  0,  7,  32'h12345000, ADD,  NEXT, 5'b10000); // LUI x7
        vecs[9]  = mk(32'h00208033, 9'd40,  1,  2,  0,  32'h0,        ADD,  NEXT, 5'b00000); // ADD x0,x1,x2
        vecs[10] = mk(32'h00008067, 9'd44,  1,  0,  0,  32'h0,        ADD,  JALR, 5'b00000); // JALR x0,0(x1)
        vecs[11] = mk(32'hC000C093, 9'h1FC, 1,  0,  1,  32'hFFFFFC00, XOR,  NEXT, 5'b10000); // XORI x1,x1,-1024

        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, RST_EXP);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        resetn = 1'b1;

        // back-to-back table at full throughput
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_ir     = ir_t'(vecs[i].ir);
            bus.in_pc     = vecs[i].d.pc;
            bus.out_ready = 1'b1;
            #1 chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1 chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].d);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 chk("drain.valid", 32'(bus.out_valid), 32'd0);

        // backpressure: hold for 3 cycles, then release with a new input
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_ir     = ir_t'(vecs[0].ir);
        bus.in_pc     = 9'h010;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_ir = ir_t'(vecs[1].ir);
        bus.in_pc = 9'h014;
        for (int k = 0; k < 3; k++) begin
            vec_t h;
            h = vecs[0];
            h.d.pc = 9'h010;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
            chk_out($sformatf("hold%0d", k), 1'b1, h.d);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1 chk("release.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        begin
            vec_t h;
            h = vecs[1];
            h.d.pc = 9'h014;
            #1 chk_out("release", 1'b1, h.d);
        end

        // flush alongside an input transfer of LW x2,8(x1)
        @(negedge clk);
        bus.in_ir = ir_t'(32'h0080A103);
        bus.in_pc = 9'h020;
        bus.flush = 1'b1;
        #1 chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 chk_out("flush", 1'b0, RST_EXP);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 chk("postflush.valid", 32'(bus.out_valid), 32'd0);

        // asynchronous reset while holding under backpressure
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_ir     = ir_t'(vecs[8].ir);
        bus.in_pc     = 9'h030;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 chk("arst.pre_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        #2 resetn = 1'b0;
        #1 chk_out("arst", 1'b0, RST_EXP);
        @(negedge clk);
        resetn = 1'b1;

        // randomized traffic against the reference model
        m_valid = 1'b0;
        m_dec   = RST_EXP;
        for (int c = 0; c < 400; c++) begin
            logic acc;
            @(negedge clk);
            chk_out("rnd", m_valid, m_dec);
            w = $urandom();
            w[6:0] = ops[$urandom_range(10, 0)];
            bus.in_valid  = ($urandom_range(3, 0) != 0);
            bus.in_ir     = ir_t'(w);
            bus.in_pc     = pc_t'($urandom());
            bus.out_ready = ($urandom_range(2, 0) != 0);
            bus.flush     = ($urandom_range(15, 0) == 0);
            #1 chk("rnd.in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            acc = bus.in_valid && (!m_valid || bus.out_ready);
            if (bus.flush) begin
                m_valid = 1'b0;
                m_dec   = RST_EXP;
            end else if (acc) begin
                m_valid = 1'b1;
                m_dec   = ref_decode(w, bus.in_pc);
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk_out("rnd_end", m_valid, m_dec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
